// File: rtl/neuron_pkg.sv
// Shared types for the bit-serial neuron datapath: operation modes and FSM states.
package neuron_pkg;

  typedef enum logic [1:0] {
    MODE_ADD = 2'b00,
    MODE_SUB = 2'b01,
    MODE_ACC = 2'b10,
    MODE_CLR = 2'b11
  } fa_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } fa_state_e;

endpackage

// File: rtl/fa_cell.sv
// Single-bit combinational full adder; the only arithmetic element of the serial datapath.
module fa_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic ci_i,
  output logic s_o,
  output logic co_o
);

  assign s_o  = a_i ^ b_i ^ ci_i;
  assign co_o = (a_i & b_i) | (ci_i & (a_i ^ b_i));

endmodule

// File: rtl/serial_fa_accum.sv
// Bit-serial add/subtract/accumulate unit, LSB first over W cycles, with a membrane accumulator.
// Handshake: a transfer happens on a rising edge where valid && ready; in_ready is high only in
// IDLE, out_valid only in DONE, and sum/cout hold steady until the output transfer completes.
module serial_fa_accum
  import neuron_pkg::*;
#(
  parameter int W   = 8,
  parameter bit SAT = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   mode,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic [W-1:0] acc
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  fa_state_e      state_q, state_d;
  fa_mode_e       mode_q, mode_d;
  fa_mode_e       mode_in;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   opa_q, opa_d;
  logic [W-1:0]   opb_q, opb_d;
  logic [W-1:0]   res_q, res_d;
  logic           carry_q, carry_d;
  logic [W-1:0]   sum_q, sum_d;
  logic           cout_q, cout_d;
  logic [W-1:0]   acc_q, acc_d;
  logic           fa_s, fa_c;
  logic [W-1:0]   final_w;

  fa_cell u_fa (
    .a_i  (opa_q[0]),
    .b_i  (opb_q[0]),
    .ci_i (carry_q),
    .s_o  (fa_s),
    .co_o (fa_c)
  );

  assign mode_in = fa_mode_e'(mode);
  // Result word as it stands once the current bit has been shifted in at the MSB.
  assign final_w = {fa_s, res_q[W-1:1]};

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    acc_d   = acc_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (mode_in == MODE_CLR) begin
            acc_d   = '0;
            sum_d   = '0;
            cout_d  = 1'b0;
            state_d = ST_DONE;
          end else begin
            mode_d = mode_in;
            opa_d  = a;
            unique case (mode_in)
              MODE_ADD: opb_d = b;
              MODE_SUB: opb_d = ~b;
              default:  opb_d = acc_q;
            endcase
            // Subtraction is a + ~b + 1: the +1 enters through the initial carry.
            carry_d = (mode_in == MODE_SUB);
            cnt_d   = '0;
            state_d = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        opa_d   = {1'b0, opa_q[W-1:1]};
        opb_d   = {1'b0, opb_q[W-1:1]};
        res_d   = final_w;
        carry_d = fa_c;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = ST_DONE;
          sum_d   = final_w;
          cout_d  = fa_c;
          if (mode_q == MODE_ACC) begin
            if (SAT && fa_c) begin
              acc_d = '1;
              sum_d = '1;
            end else begin
              acc_d = final_w;
            end
          end
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_ADD;
      cnt_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      acc_q   <= acc_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign acc       = acc_q;

endmodule

// File: tb/tb_serial_fa_accum.sv
// Directed bench for serial_fa_accum: one saturating and one wrapping instance share all inputs.
module tb_serial_fa_accum;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [1:0]   mode;
  logic [W-1:0] a, b;
  logic         out_ready;

  logic         in_ready_s, out_valid_s, cout_s;
  logic [W-1:0] sum_s, acc_s;
  logic         in_ready_w, out_valid_w, cout_w;
  logic [W-1:0] sum_w, acc_w;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_fa_accum #(.W(W), .SAT(1'b1)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s), .mode(mode),
    .a(a), .b(b), .out_valid(out_valid_s), .out_ready(out_ready), .sum(sum_s),
    .cout(cout_s), .acc(acc_s)
  );

  serial_fa_accum #(.W(W), .SAT(1'b0)) dut_wrap (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w), .mode(mode),
    .a(a), .b(b), .out_valid(out_valid_w), .out_ready(out_ready), .sum(sum_w),
    .cout(cout_w), .acc(acc_w)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Presents one operation, counts edges after the accept edge until out_valid, then
  // checks the result of both instances while DONE is visible.
  task automatic run_op(input string tag, input logic [1:0] m, input logic [W-1:0] va,
                        input logic [W-1:0] vb, input int exp_lat,
                        input logic [W-1:0] e_sum_s, input logic e_cout_s, input logic [W-1:0] e_acc_s,
                        input logic [W-1:0] e_sum_w, input logic e_cout_w, input logic [W-1:0] e_acc_w);
    int n;
    @(negedge clk);
    check({tag, "_in_ready"}, {31'd0, in_ready_s}, 32'd1);
    in_valid = 1'b1;
    mode     = m;
    a        = va;
    b        = vb;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a        = 8'hA5;
    b        = 8'h5A;
    n = 0;
    while (!out_valid_s && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_latency"}, n, exp_lat);
    check({tag, "_sum"},  {24'd0, sum_s},  {24'd0, e_sum_s});
    check({tag, "_cout"}, {31'd0, cout_s}, {31'd0, e_cout_s});
    check({tag, "_acc"},  {24'd0, acc_s},  {24'd0, e_acc_s});
    check({tag, "_sum_wrap"},  {24'd0, sum_w},  {24'd0, e_sum_w});
    check({tag, "_cout_wrap"}, {31'd0, cout_w}, {31'd0, e_cout_w});
    check({tag, "_acc_wrap"},  {24'd0, acc_w},  {24'd0, e_acc_w});
    if (out_ready) begin
      @(posedge clk);
      #1;
      check({tag, "_back_idle"}, {30'd0, in_ready_s, out_valid_s}, 32'b10);
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    mode      = 2'b00;
    a         = '0;
    b         = '0;
    out_ready = 1'b1;
    #1;
    check("reset_ready_valid", {30'd0, in_ready_s, out_valid_s}, 32'b10);
    check("reset_sum_cout_acc", {15'd0, sum_s, cout_s, acc_s}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    run_op("add_3c_05", 2'b00, 8'h3C, 8'h05, 8, 8'h41, 1'b0, 8'h00, 8'h41, 1'b0, 8'h00);
    run_op("add_ff_01", 2'b00, 8'hFF, 8'h01, 8, 8'h00, 1'b1, 8'h00, 8'h00, 1'b1, 8'h00);
    run_op("sub_10_01", 2'b01, 8'h10, 8'h01, 8, 8'h0F, 1'b1, 8'h00, 8'h0F, 1'b1, 8'h00);
    run_op("sub_01_02", 2'b01, 8'h01, 8'h02, 8, 8'hFF, 1'b0, 8'h00, 8'hFF, 1'b0, 8'h00);
    // 200 then 100: 300 saturates to 255, or wraps to 44, overflow flagged in both.
    run_op("acc_200", 2'b10, 8'd200, 8'h77, 8, 8'd200, 1'b0, 8'd200, 8'd200, 1'b0, 8'd200);
    run_op("acc_100", 2'b10, 8'd100, 8'h77, 8, 8'd255, 1'b1, 8'd255, 8'd44, 1'b1, 8'd44);

    // Backpressure: result must hold and a pending request must not be taken.
    out_ready = 1'b0;
    run_op("bp_add", 2'b00, 8'h12, 8'h34, 8, 8'h46, 1'b0, 8'd255, 8'h46, 1'b0, 8'd44);
    @(negedge clk);
    in_valid = 1'b1;
    mode     = 2'b11;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp_hold_state", {30'd0, in_ready_s, out_valid_s}, 32'b01);
      check("bp_hold_sum_acc", {16'd0, sum_s, acc_s}, {16'd0, 8'h46, 8'd255});
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release", {30'd0, in_ready_s, out_valid_s}, 32'b10);
    check("bp_sum_held_idle", {24'd0, sum_s}, {24'd0, 8'h46});

    // CLR goes straight to DONE on the accept edge.
    run_op("clr", 2'b11, 8'hFF, 8'hFF, 0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);

    // Reset in the middle of a shift (while bit 3 is being processed).
    run_op("pre_rst_acc", 2'b10, 8'd9, 8'h00, 8, 8'd9, 1'b0, 8'd9, 8'd9, 1'b0, 8'd9);
    @(negedge clk);
    in_valid = 1'b1;
    mode     = 2'b00;
    a        = 8'h3C;
    b        = 8'h05;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_ready_valid", {30'd0, in_ready_s, out_valid_s}, 32'b10);
    check("midrst_sum_cout_acc", {15'd0, sum_s, cout_s, acc_s}, 32'd0);
    check("midrst_wrap_acc", {24'd0, acc_w}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op("post_rst_add", 2'b00, 8'h3C, 8'h05, 8, 8'h41, 1'b0, 8'h00, 8'h41, 1'b0, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
